rx_iq_sample_scheduler: RTL and testbench

//  Buffers decimated RX1/RX2 IQ sample sets from the DDC and hands one frame to the STM32 bus

---
 rtl/rx_iq_sample_scheduler.sv | 157 +++++++++++++++
 tb/tb_rx_iq_sample_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_sample_scheduler.sv
// RX1/RX2 IQ frame FIFO with prefill scheduling between the DDC chains and the STM32 bus interface.
// Build option: define RX_IQ_SCHED_STATS_EN for live saturating drop/underrun counters.
module rx_iq_sample_scheduler #(
  parameter int IQ_WIDTH   = 24,
  parameter int DEPTH_LOG2 = 4,
  parameter int PREFILL    = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  stream_enable,
  input  logic                  rx_valid,
  input  logic [IQ_WIDTH-1:0]   rx1_i,
  input  logic [IQ_WIDTH-1:0]   rx1_q,
  input  logic [IQ_WIDTH-1:0]   rx2_i,
  input  logic [IQ_WIDTH-1:0]   rx2_q,
  input  logic                  rx2_enable,
  input  logic                  read_req,
  output logic [IQ_WIDTH-1:0]   rd_rx1_i,
  output logic [IQ_WIDTH-1:0]   rd_rx1_q,
  output logic [IQ_WIDTH-1:0]   rd_rx2_i,
  output logic [IQ_WIDTH-1:0]   rd_rx2_q,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [1:0]            sched_state,
  output logic                  overrun,
  output logic                  underrun,
  input  logic                  flag_clear,
  output logic [15:0]           drop_count,
  output logic [15:0]           underrun_count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL    = LW'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   PREFILL_LVL = LW'(PREFILL);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE     = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                  state;
  logic [4*IQ_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr;
  logic [DEPTH_LOG2-1:0]   rptr;
  logic [DEPTH_LOG2:0]     level;
  logic [DEPTH_LOG2:0]     level_next;
  logic [IQ_WIDTH-1:0]     rx2_i_r;
  logic [IQ_WIDTH-1:0]     rx2_q_r;
  logic                    active;
  logic                    full;
  logic                    rd_ok;
  logic                    rd_fail;
  logic                    wr_ok;
  logic                    drop;

  // A read at full frees the slot the concurrent write lands in.
  always_comb begin
    active     = stream_enable && (state != IDLE);
    full       = (level == FULL_LVL);
    rd_ok      = active && read_req && (state == RUN) && (level != '0);
    rd_fail    = active && read_req && !rd_ok;
    wr_ok      = active && rx_valid && (!full || rd_ok);
    drop       = active && rx_valid && full && !rd_ok;
    level_next = level;
    if (wr_ok && !rd_ok)
      level_next = level + LVL_ONE;
    else if (!wr_ok && rd_ok)
      level_next = level - LVL_ONE;
  end

  always_ff @(posedge clk_in) begin
    if (wr_ok)
      mem[wptr] <= {rx1_i, rx1_q, rx2_i, rx2_q};
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      rd_rx1_i <= '0;
      rd_rx1_q <= '0;
      rx2_i_r  <= '0;
      rx2_q_r  <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (!stream_enable || state == IDLE) begin
        state    <= stream_enable ? FILL : IDLE;
        wptr     <= '0;
        rptr     <= '0;
        level    <= '0;
        rd_valid <= 1'b0;
      end else begin
        level <= level_next;
        if (wr_ok)
          wptr <= wptr + PTR_ONE;
        if (rd_ok) begin
          rptr <= rptr + PTR_ONE;
          {rd_rx1_i, rd_rx1_q, rx2_i_r, rx2_q_r} <= mem[rptr];
          rd_valid <= 1'b1;
        end else if (read_req) begin
          rd_valid <= 1'b0;
        end
        if (state == RUN && rd_fail)
          state <= FILL;
        else if (state == FILL && level_next >= PREFILL_LVL)
          state <= RUN;
      end

      if (drop)
        overrun <= 1'b1;
      else if (flag_clear)
        overrun <= 1'b0;
      if (rd_fail)
        underrun <= 1'b1;
      else if (flag_clear)
        underrun <= 1'b0;
    end
  end

  // RX2 is always stored; the enable only masks what is presented.
  assign rd_rx2_i    = rx2_enable ? rx2_i_r : '0;
  assign rd_rx2_q    = rx2_enable ? rx2_q_r : '0;
  assign fifo_level  = level;
  assign sched_state = state;

`ifdef RX_IQ_SCHED_STATS_EN
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      drop_count     <= '0;
      underrun_count <= '0;
    end else begin
      if (drop)
        drop_count <= flag_clear ? 16'd1 :
                      (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
      else if (flag_clear)
        drop_count <= '0;
      if (rd_fail)
        underrun_count <= flag_clear ? 16'd1 :
                          (underrun_count == 16'hFFFF) ? underrun_count : underrun_count + 16'd1;
      else if (flag_clear)
        underrun_count <= '0;
    end
  end
`else
  assign drop_count     = '0;
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_rx_iq_sample_scheduler.sv
// Self-checking bench for rx_iq_sample_scheduler: directed scenarios plus random traffic
// compared against a queue-based frame model.
module tb_rx_iq_sample_scheduler;

  localparam int IQ_WIDTH = 24;
  localparam int DEPTH    = 16;
  localparam int PREFILL  = 4;

  logic clk = 1'b0;
  logic rst, en, rxv, r2en, req, fclr;
  logic [IQ_WIDTH-1:0] r1i, r1q, r2i, r2q;
  logic [IQ_WIDTH-1:0] rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q;
  logic rd_valid, overrun, underrun;
  logic [4:0] fifo_level;
  logic [1:0] sched_state;
  logic [15:0] drop_count, underrun_count;

  int nassert = 0;
  int nfail   = 0;

  // Reference model: frames held in a queue, everything else plain variables.
  logic [95:0] q[$];
  logic [95:0] m_rd;
  int          m_state;
  bit          m_rdv, m_ovr, m_udr;
  int          m_drop, m_ucnt;

  always #5 clk = ~clk;

  rx_iq_sample_scheduler #(.IQ_WIDTH(IQ_WIDTH), .DEPTH_LOG2(4), .PREFILL(PREFILL)) dut (
    .clk_in(clk), .reset(rst), .stream_enable(en), .rx_valid(rxv),
    .rx1_i(r1i), .rx1_q(r1q), .rx2_i(r2i), .rx2_q(r2q), .rx2_enable(r2en),
    .read_req(req), .rd_rx1_i(rd_rx1_i), .rd_rx1_q(rd_rx1_q),
    .rd_rx2_i(rd_rx2_i), .rd_rx2_q(rd_rx2_q), .rd_valid(rd_valid),
    .fifo_level(fifo_level), .sched_state(sched_state), .overrun(overrun),
    .underrun(underrun), .flag_clear(fclr), .drop_count(drop_count),
    .underrun_count(underrun_count)
  );

  function automatic logic [95:0] exp_rd();
    return {m_rd[95:48], r2en ? m_rd[47:0] : 48'd0};
  endfunction

  function automatic int exp_drop();
`ifdef RX_IQ_SCHED_STATS_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_ucnt();
`ifdef RX_IQ_SCHED_STATS_EN
    return m_ucnt;
`else
    return 0;
`endif
  endfunction

  function automatic int sat_inc(input int c, input bit ev, input bit clr);
    if (ev) return clr ? 1 : (c == 65535 ? c : c + 1);
    if (clr) return 0;
    return c;
  endfunction

  task automatic m_reset();
    q.delete();
    m_rd = '0; m_state = 0; m_rdv = 0; m_ovr = 0; m_udr = 0; m_drop = 0; m_ucnt = 0;
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic step();
    bit ok, bad, dropped;
    ok = 0; bad = 0; dropped = 0;
    if (!en || m_state == 0) begin
      m_state = en ? 1 : 0;
      q.delete();
      m_rdv = 0;
    end else begin
      ok  = req && m_state == 2 && q.size() > 0;
      bad = req && !ok;
      if (ok) begin
        m_rd = q.pop_front();
        m_rdv = 1;
      end else if (req) begin
        m_rdv = 0;
      end
      if (rxv) begin
        if (q.size() < DEPTH) q.push_back({r1i, r1q, r2i, r2q});
        else dropped = 1;
      end
      if (m_state == 2 && bad) m_state = 1;
      else if (m_state == 1 && q.size() >= PREFILL) m_state = 2;
    end
    m_ovr  = dropped ? 1'b1 : (fclr ? 1'b0 : m_ovr);
    m_udr  = bad ? 1'b1 : (fclr ? 1'b0 : m_udr);
    m_drop = sat_inc(m_drop, dropped, fclr);
    m_ucnt = sat_inc(m_ucnt, bad, fclr);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [95:0] f);
    {r1i, r1q, r2i, r2q} = f;
    rxv = 1'b1;
    step();
    rxv = 1'b0;
  endtask

  task automatic pop();
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  function automatic logic [95:0] rand_frame();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    nassert++;
    if ({rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q, rd_valid, fifo_level, sched_state} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: got rd=%h v=%b lvl=%0d st=%0d, want all zero",
               {rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q}, rd_valid, fifo_level, sched_state);
    end
    nassert++;
    if ({overrun, underrun, drop_count, underrun_count} !== '0) begin
      nfail++;
      $display("FAIL reset_flags: got ovr=%b udr=%b dc=%0d uc=%0d, want 0", overrun, underrun,
               drop_count, underrun_count);
    end
  endtask

  task automatic test_reset_midstream();
    en = 1'b1;
    step();
    for (int i = 0; i < 7; i++) push(rand_frame());
    pop();
    nassert++;
    if (fifo_level !== 5'd6 || rd_valid !== 1'b1) begin
      nfail++;
      $display("FAIL midstream_pre: got lvl=%0d v=%b, want lvl=6 v=1", fifo_level, rd_valid);
    end
    push(rand_frame());
    nassert++;
    if (fifo_level !== 5'd7) begin
      nfail++;
      $display("FAIL midstream_lvl7: got %0d, want 7", fifo_level);
    end
    rst = 1'b1;
    en = 1'b0;
    #2;
    m_reset();
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_prefill();
    logic [95:0] first;
    en = 1'b1;
    step();
    first = rand_frame();
    push(first);
    push(rand_frame());
    push(rand_frame());
    pop();
    nassert++;
    if (underrun !== 1'b1 || rd_valid !== 1'b0 || sched_state !== 2'd1) begin
      nfail++;
      $display("FAIL prefill_underrun: got udr=%b v=%b st=%0d, want 1 0 1", underrun, rd_valid,
               sched_state);
    end
    push(rand_frame());
    nassert++;
    if (sched_state !== 2'd2 || fifo_level !== 5'd4) begin
      nfail++;
      $display("FAIL prefill_run: got st=%0d lvl=%0d, want 2 4", sched_state, fifo_level);
    end
    pop();
    nassert++;
    if ({rd_rx1_i, rd_rx1_q} !== first[95:48] || rd_valid !== 1'b1 || fifo_level !== 5'd3) begin
      nfail++;
      $display("FAIL prefill_first_read: got rx1=%h v=%b lvl=%0d, want %h 1 3",
               {rd_rx1_i, rd_rx1_q}, rd_valid, fifo_level, first[95:48]);
    end
    nassert++;
    if (underrun_count !== 16'(exp_ucnt())) begin
      nfail++;
      $display("FAIL prefill_ucnt: got %0d, want %0d", underrun_count, exp_ucnt());
    end
  endtask

  task automatic test_overrun();
    en = 1'b0;
    step();
    en = 1'b1;
    fclr = 1'b1;
    step();
    fclr = 1'b0;
    for (int i = 0; i < 17; i++) push(rand_frame());
    nassert++;
    if (fifo_level !== 5'd16 || overrun !== 1'b1) begin
      nfail++;
      $display("FAIL overrun_full: got lvl=%0d ovr=%b, want 16 1", fifo_level, overrun);
    end
    nassert++;
    if (drop_count !== 16'(exp_drop())) begin
      nfail++;
      $display("FAIL overrun_dropcount: got %0d, want %0d", drop_count, exp_drop());
    end
  endtask

  task automatic test_full_simul();
    logic [95:0] newest;
    logic [95:0] want;
    newest = rand_frame();
    {r1i, r1q, r2i, r2q} = newest;
    rxv = 1'b1;
    req = 1'b1;
    step();
    rxv = 1'b0;
    req = 1'b0;
    nassert++;
    if (fifo_level !== 5'd16 || overrun !== 1'b1 || drop_count !== 16'(exp_drop())) begin
      nfail++;
      $display("FAIL full_simul: got lvl=%0d ovr=%b dc=%0d, want 16 1 %0d", fifo_level, overrun,
               drop_count, exp_drop());
    end
    for (int i = 0; i < 16; i++) begin
      pop();
      want = exp_rd();
      nassert++;
      if ({rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q} !== want || rd_valid !== 1'b1) begin
        nfail++;
        $display("FAIL drain_order[%0d]: got %h v=%b, want %h v=1", i,
                 {rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q}, rd_valid, want);
      end
    end
    nassert++;
    if ({rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q} !== newest || fifo_level !== 5'd0) begin
      nfail++;
      $display("FAIL drain_last_new: got %h lvl=%0d, want %h 0",
               {rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q}, fifo_level, newest);
    end
  endtask

  task automatic test_rx2_gate();
    logic [95:0] f;
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    f = rand_frame();
    f[47:24] = 24'h123456;
    push(f);
    for (int i = 0; i < 3; i++) push(rand_frame());
    r2en = 1'b0;
    pop();
    nassert++;
    if (rd_rx2_i !== 24'd0 || rd_rx2_q !== 24'd0 || {rd_rx1_i, rd_rx1_q} !== f[95:48]) begin
      nfail++;
      $display("FAIL rx2_masked: got rx2_i=%h rx2_q=%h rx1=%h, want 0 0 %h", rd_rx2_i, rd_rx2_q,
               {rd_rx1_i, rd_rx1_q}, f[95:48]);
    end
    r2en = 1'b1;
    #1;
    nassert++;
    if (rd_rx2_i !== 24'h123456 || rd_rx2_q !== f[23:0]) begin
      nfail++;
      $display("FAIL rx2_unmasked: got rx2_i=%h rx2_q=%h, want 123456 %h", rd_rx2_i, rd_rx2_q,
               f[23:0]);
    end
  endtask

  task automatic test_flush();
    push(rand_frame());
    push(rand_frame());
    nassert++;
    if (fifo_level !== 5'd5) begin
      nfail++;
      $display("FAIL flush_pre: got lvl=%0d, want 5", fifo_level);
    end
    en = 1'b0;
    step();
    nassert++;
    if (sched_state !== 2'd0 || fifo_level !== 5'd0 || rd_valid !== 1'b0) begin
      nfail++;
      $display("FAIL flush_idle: got st=%0d lvl=%0d v=%b, want 0 0 0", sched_state, fifo_level,
               rd_valid);
    end
    en = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      pop();
      nassert++;
      if (rd_valid !== 1'b0 || underrun !== 1'b1 || sched_state !== 2'd1 ||
          underrun_count !== 16'(exp_ucnt())) begin
        nfail++;
        $display("FAIL flush_refill_underrun[%0d]: got v=%b udr=%b st=%0d uc=%0d, want 0 1 1 %0d",
                 k, rd_valid, underrun, sched_state, underrun_count, exp_ucnt());
      end
      push(rand_frame());
    end
    pop();
    nassert++;
    if (rd_valid !== 1'b1 || sched_state !== 2'd2 || fifo_level !== 5'd3) begin
      nfail++;
      $display("FAIL flush_refill_serve: got v=%b st=%0d lvl=%0d, want 1 2 3", rd_valid,
               sched_state, fifo_level);
    end
  endtask

  task automatic test_random();
    logic [95:0] want;
    for (int i = 0; i < 600; i++) begin
      {r1i, r1q, r2i, r2q} = rand_frame();
      en   = ($urandom_range(0, 99) < 97);
      rxv  = ($urandom_range(0, 99) < 55);
      req  = ($urandom_range(0, 99) < 45);
      fclr = ($urandom_range(0, 99) < 5);
      r2en = ($urandom_range(0, 99) < 80);
      step();
      want = exp_rd();
      nassert++;
      if ({rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q} !== want || rd_valid !== m_rdv) begin
        nfail++;
        $display("FAIL rand_data[%0d]: got %h v=%b, want %h v=%b", i,
                 {rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q}, rd_valid, want, m_rdv);
      end
      nassert++;
      if (fifo_level !== 5'(q.size()) || sched_state !== 2'(m_state)) begin
        nfail++;
        $display("FAIL rand_level_state[%0d]: got lvl=%0d st=%0d, want %0d %0d", i, fifo_level,
                 sched_state, q.size(), m_state);
      end
      nassert++;
      if (overrun !== m_ovr || underrun !== m_udr || drop_count !== 16'(exp_drop()) ||
          underrun_count !== 16'(exp_ucnt())) begin
        nfail++;
        $display("FAIL rand_flags[%0d]: got ovr=%b udr=%b dc=%0d uc=%0d, want %b %b %0d %0d", i,
                 overrun, underrun, drop_count, underrun_count, m_ovr, m_udr, exp_drop(),
                 exp_ucnt());
      end
    end
    rxv = 1'b0; req = 1'b0; fclr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rxv = 1'b0; r2en = 1'b1; req = 1'b0; fclr = 1'b0;
    r1i = '0; r1q = '0; r2i = '0; r2q = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    test_reset_midstream();
    test_prefill();
    test_overrun();
    test_full_simul();
    test_rx2_gate();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
